r5p_gpio_ctrl: RTL and testbench

- Memory-mapped GPIO controller for the R5P SoC.
- Sequences the GPIO pin datapath: it drives the per-pin output value (gpio_o) and output enable (gpio_e), and samples the already-synchronized pin inputs (gpio_i).
- Adds sticky rise/fall edge capture and a level interrupt to the CPU.
- Sits between the SoC peripheral bus (valid/ready, 1-cycle read latency) and the board-level tristate pin logic.

---
 rtl/r5p_gpio_pkg.sv | 16 +
 rtl/r5p_gpio_debounce.sv | 60 ++++++
 rtl/r5p_gpio_ctrl.sv | 156 +++++++++++++++
 tb/tb_r5p_gpio_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5p_gpio_pkg.sv
// r5p_gpio_pkg: register offsets and shared types for the R5P GPIO controller
package r5p_gpio_pkg;

    // Byte offsets of the word registers; address bits [4:0] select among them.
    localparam logic [4:0] GPIO_OUT  = 5'h00;
    localparam logic [4:0] GPIO_ENA  = 5'h04;
    localparam logic [4:0] GPIO_IN   = 5'h08;
    localparam logic [4:0] GPIO_RISE = 5'h0C;
    localparam logic [4:0] GPIO_FALL = 5'h10;
    localparam logic [4:0] GPIO_IRE  = 5'h14;
    localparam logic [4:0] GPIO_IFE  = 5'h18;
    localparam logic [4:0] GPIO_TGL  = 5'h1C;

    typedef logic [32-1:0] gpio_reg_t;

endpackage

// File: rtl/r5p_gpio_debounce.sv
// r5p_gpio_debounce: per-pin 3-sample input filter driven by a sample prescaler
//   clk, rst_n : clock, asynchronous active-low reset
//   gpio_i     : synchronized pin inputs
//   filt_o     : filtered pin values
// Only instantiated when GPIO_DEBOUNCE_EN is defined.
module r5p_gpio_debounce #(
    parameter int GW  = 32,
    parameter int DIV = 1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [GW-1:0] gpio_i,
    output logic [GW-1:0] filt_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] pre_q;
    logic          tick;
    logic          init_q;
    logic [GW-1:0] filt_q;
    logic [1:0]    cnt_q [GW];

    assign tick = pre_q == CW'(DIV - 1);

    // Before the first load the raw input is passed through, so the edge
    // detector seeds its history from the real pin level, not the reset 0.
    assign filt_o = init_q ? filt_q : gpio_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            init_q <= 1'b0;
            filt_q <= '0;
            for (int i = 0; i < GW; i++) cnt_q[i] <= 2'd0;
        end else begin
            pre_q  <= tick ? '0 : pre_q + 1'b1;
            init_q <= 1'b1;
            if (!init_q) begin
                filt_q <= gpio_i;
            end else if (tick) begin
                // A single-bit sample differing from the filtered value can only
                // be its inverse, so counting differing samples is enough.
                for (int i = 0; i < GW; i++) begin
                    if (gpio_i[i] != filt_q[i]) begin
                        if (cnt_q[i] == 2'd2) begin
                            filt_q[i] <= gpio_i[i];
                            cnt_q[i]  <= 2'd0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 2'd1;
                        end
                    end else begin
                        cnt_q[i] <= 2'd0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/r5p_gpio_ctrl.sv
// r5p_gpio_ctrl: memory-mapped GPIO controller with sticky edge flags and level irq
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus_vld/wen/adr/ben/wdt : peripheral bus request (valid/ready, always ready)
//   bus_rdt, bus_err    : registered read response, one cycle after accept
//   bus_rdy             : request accepted (constant 1)
//   gpio_o, gpio_e      : pin output value and output enable
//   gpio_i              : synchronized pin inputs
//   irq                 : registered interrupt request
// Optional macro GPIO_DEBOUNCE_EN inserts r5p_gpio_debounce on the input path.
module r5p_gpio_ctrl
    import r5p_gpio_pkg::*;
#(
    parameter int GW  = 32,
    parameter int AW  = 5,
    parameter int BW  = 32,
    parameter int DIV = 1000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bus_vld,
    input  logic            bus_wen,
    input  logic [AW-1:0]   bus_adr,
    input  logic [BW/8-1:0] bus_ben,
    input  logic [BW-1:0]   bus_wdt,
    output logic [BW-1:0]   bus_rdt,
    output logic            bus_err,
    output logic            bus_rdy,
    output logic [GW-1:0]   gpio_o,
    output logic [GW-1:0]   gpio_e,
    input  logic [GW-1:0]   gpio_i,
    output logic            irq
);

    logic [4:0]    sel;
    logic          bad;
    logic          wr;
    logic          rd;
    gpio_reg_t     bmask;
    logic [GW-1:0] wm;
    logic [GW-1:0] wd;
    logic [GW-1:0] in_cur;

    logic [GW-1:0] out_q, out_d;
    logic [GW-1:0] ena_q, ena_d;
    logic [GW-1:0] rise_q, rise_d;
    logic [GW-1:0] fall_q, fall_d;
    logic [GW-1:0] ire_q, ire_d;
    logic [GW-1:0] ife_q, ife_d;
    logic [GW-1:0] in_q;
    logic [GW-1:0] rise_e;
    logic [GW-1:0] fall_e;
    logic          run_q;
    logic          irq_q, irq_d;
    gpio_reg_t     rdt_q, rdt_d;
    logic          err_q;
    gpio_reg_t     rval;
    logic          unused_ok;

    assign sel = {bus_adr[4:2], 2'b00};

    generate
        if (AW > 5) begin : g_err
            assign bad = |bus_adr[AW-1:5];
        end else begin : g_noerr
            assign bad = 1'b0;
        end
    endgenerate

    for (genvar b = 0; b < BW / 8; b++) begin : g_ben
        assign bmask[8*b +: 8] = {8{bus_ben[b]}};
    end

    assign wr = bus_vld & bus_wen & ~bad;
    assign rd = bus_vld & ~bus_wen;
    assign wm = bmask[GW-1:0];
    assign wd = bus_wdt[GW-1:0] & wm;

`ifdef GPIO_DEBOUNCE_EN
    r5p_gpio_debounce #(
        .GW  (GW),
        .DIV (DIV)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .gpio_i (gpio_i),
        .filt_o (in_cur)
    );
`else
    localparam int unused_div = DIV;
    assign in_cur = gpio_i;
`endif

    always_comb begin
        // run_q suppresses edges in the first cycle after reset while in_q
        // is seeded from the pins.
        rise_e = run_q ? (in_cur & ~in_q) : '0;
        fall_e = run_q ? (~in_cur & in_q) : '0;
        out_d  = (wr && sel == GPIO_OUT) ? ((out_q & ~wm) | wd) :
                 (wr && sel == GPIO_TGL) ? (out_q ^ wd) : out_q;
        ena_d  = (wr && sel == GPIO_ENA) ? ((ena_q & ~wm) | wd) : ena_q;
        ire_d  = (wr && sel == GPIO_IRE) ? ((ire_q & ~wm) | wd) : ire_q;
        ife_d  = (wr && sel == GPIO_IFE) ? ((ife_q & ~wm) | wd) : ife_q;
        // Clear is applied before the new edge is OR'ed in, so a same-cycle
        // edge keeps its flag.
        rise_d = (rise_q & ~((wr && sel == GPIO_RISE) ? wd : '0)) | rise_e;
        fall_d = (fall_q & ~((wr && sel == GPIO_FALL) ? wd : '0)) | fall_e;
        irq_d  = |((rise_q & ire_q) | (fall_q & ife_q));
        rval   = (sel == GPIO_OUT)  ? 32'(out_q)  :
                 (sel == GPIO_ENA)  ? 32'(ena_q)  :
                 (sel == GPIO_IN)   ? 32'(in_cur) :
                 (sel == GPIO_RISE) ? 32'(rise_q) :
                 (sel == GPIO_FALL) ? 32'(fall_q) :
                 (sel == GPIO_IRE)  ? 32'(ire_q)  :
                 (sel == GPIO_IFE)  ? 32'(ife_q)  : '0;
        rdt_d  = bad ? '0 : rval;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            ena_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            ire_q  <= '0;
            ife_q  <= '0;
            in_q   <= '0;
            run_q  <= 1'b0;
            irq_q  <= 1'b0;
            rdt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            ena_q  <= ena_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ire_q  <= ire_d;
            ife_q  <= ife_d;
            in_q   <= in_cur;
            run_q  <= 1'b1;
            irq_q  <= irq_d;
            if (rd) begin
                rdt_q <= rdt_d;
                err_q <= bad;
            end
        end
    end

    assign bus_rdt   = BW'(rdt_q);
    assign bus_err   = err_q;
    assign bus_rdy   = 1'b1;
    assign gpio_o    = out_q;
    assign gpio_e    = ena_q;
    assign irq       = irq_q;
    assign unused_ok = ^{bus_adr[1:0], bus_wdt, bmask};

endmodule

// File: tb/tb_r5p_gpio_ctrl.sv
// tb_r5p_gpio_ctrl: directed table-driven bench for r5p_gpio_ctrl (GW=32, AW=6, DIV=4)
module tb_r5p_gpio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_vld;
    logic        bus_wen;
    logic [5:0]  bus_adr;
    logic [3:0]  bus_ben;
    logic [31:0] bus_wdt;
    logic [31:0] bus_rdt;
    logic        bus_err;
    logic        bus_rdy;
    logic [31:0] gpio_o;
    logic [31:0] gpio_e;
    logic [31:0] gpio_i;
    logic        irq;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wen;
        logic [5:0]  adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
        logic [31:0] rdt;
        logic        err;
        logic [31:0] o;
        logic [31:0] e;
    } vec_t;

    vec_t tv[$];

    r5p_gpio_ctrl #(.GW(32), .AW(6), .BW(32), .DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_vld (bus_vld),
        .bus_wen (bus_wen),
        .bus_adr (bus_adr),
        .bus_ben (bus_ben),
        .bus_wdt (bus_wdt),
        .bus_rdt (bus_rdt),
        .bus_err (bus_err),
        .bus_rdy (bus_rdy),
        .gpio_o  (gpio_o),
        .gpio_e  (gpio_e),
        .gpio_i  (gpio_i),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        bus_vld = 1'b1;
        bus_wen = 1'b1;
        bus_adr = a;
        bus_ben = be;
        bus_wdt = d;
        @(posedge clk);
        #1;
        bus_vld = 1'b0;
        bus_wen = 1'b0;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d, output logic e);
        bus_vld = 1'b1;
        bus_wen = 1'b0;
        bus_adr = a;
        @(posedge clk);
        #1;
        bus_vld = 1'b0;
        d = bus_rdt;
        e = bus_err;
    endtask

    initial begin
        logic [31:0] r;
        logic        er;

        //            wen   adr    ben   wdt           rdt           err   gpio_o        gpio_e
        tv.push_back('{1'b0, 6'h08, 4'hF, 32'h0,        32'hFFFFFFFF, 1'b0, 32'h0,        32'h0});
        tv.push_back('{1'b0, 6'h0C, 4'hF, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0});
        tv.push_back('{1'b0, 6'h10, 4'hF, 32'h0,        32'h0,        1'b0, 32'h0,        32'h0});
        tv.push_back('{1'b1, 6'h00, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0, 32'hA5A5A5A5, 32'h0});
        tv.push_back('{1'b1, 6'h04, 4'h3, 32'hFFFFFFFF, 32'h0,        1'b0, 32'hA5A5A5A5, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h00, 4'hF, 32'h0,        32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h04, 4'hF, 32'h0,        32'h0000FFFF, 1'b0, 32'hA5A5A5A5, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h1C, 4'hF, 32'hFFFF0000, 32'h0,        1'b0, 32'h5A5AA5A5, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h1C, 4'hF, 32'h0,        32'h0,        1'b0, 32'h5A5AA5A5, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h1C, 4'h1, 32'h000000FF, 32'h0,        1'b0, 32'h5A5AA55A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h1C, 4'h2, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h5A5A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h08, 4'hF, 32'h0,        32'h0,        1'b0, 32'h5A5A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h08, 4'hF, 32'h0,        32'hFFFFFFFF, 1'b0, 32'h5A5A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h00, 4'h8, 32'h12345678, 32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h14, 4'h4, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h14, 4'hF, 32'h0,        32'h00FF0000, 1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h18, 4'hF, 32'h00000F0F, 32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h18, 4'hF, 32'h0,        32'h00000F0F, 1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h20, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h20, 4'hF, 32'h0,        32'h0,        1'b1, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h00, 4'hF, 32'h0,        32'h125A5A5A, 1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h3C, 4'hF, 32'h0,        32'h0,        1'b1, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h14, 4'hF, 32'h0,        32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b1, 6'h18, 4'hF, 32'h0,        32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});
        tv.push_back('{1'b0, 6'h0C, 4'hF, 32'h0,        32'h0,        1'b0, 32'h125A5A5A, 32'h0000FFFF});

        rst_n   = 1'b0;
        bus_vld = 1'b0;
        bus_wen = 1'b0;
        bus_adr = '0;
        bus_ben = '0;
        bus_wdt = '0;
        gpio_i  = 32'hFFFFFFFF;
        cyc(3);
        chk("rst gpio_o", gpio_o, 32'h0);
        chk("rst gpio_e", gpio_e, 32'h0);
        chk("rst irq", {31'h0, irq}, 32'h0);
        chk("rst rdt", bus_rdt, 32'h0);
        chk("rst err", {31'h0, bus_err}, 32'h0);
        chk("rst rdy", {31'h0, bus_rdy}, 32'h1);
        rst_n = 1'b1;
        cyc(2);
        chk("post-rst irq", {31'h0, irq}, 32'h0);

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].wen) begin
                bus_wr(tv[i].adr, tv[i].ben, tv[i].wdt);
            end else begin
                bus_rd(tv[i].adr, r, er);
                chk($sformatf("v%0d rdt", i), r, tv[i].rdt);
                chk($sformatf("v%0d err", i), {31'h0, er}, {31'h0, tv[i].err});
            end
            chk($sformatf("v%0d gpio_o", i), gpio_o, tv[i].o);
            chk($sformatf("v%0d gpio_e", i), gpio_e, tv[i].e);
        end

`ifndef GPIO_DEBOUNCE_EN
        // All pins fall: flags set, but no irq with enables off.
        gpio_i = 32'h0;
        cyc(2);
        bus_rd(6'h10, r, er);
        chk("fall all", r, 32'hFFFFFFFF);
        chk("fall no irq", {31'h0, irq}, 32'h0);
        bus_wr(6'h10, 4'hF, 32'hFFFFFFFF);
        bus_rd(6'h10, r, er);
        chk("fall cleared", r, 32'h0);

        // Rise on bit0 with enable: flag next cycle, irq one cycle later, w1c drops irq.
        bus_wr(6'h14, 4'hF, 32'h1);
        gpio_i = 32'h1;
        cyc(1);
        chk("irq not early", {31'h0, irq}, 32'h0);
        cyc(1);
        chk("irq set", {31'h0, irq}, 32'h1);
        bus_rd(6'h0C, r, er);
        chk("rise bit0", r, 32'h1);
        bus_wr(6'h0C, 4'hF, 32'h1);
        chk("irq holds at clear", {31'h0, irq}, 32'h1);
        cyc(1);
        chk("irq cleared", {31'h0, irq}, 32'h0);

        // Same-cycle fall edge and w1c on bit3: set wins.
        gpio_i = 32'h9;
        cyc(2);
        gpio_i = 32'h1;
        bus_wr(6'h10, 4'hF, 32'h8);
        bus_rd(6'h10, r, er);
        chk("set wins", r, 32'h8);
        bus_wr(6'h10, 4'hF, 32'h8);
        bus_rd(6'h10, r, er);
        chk("fall w1c", r, 32'h0);

        // w1c honours byte enables.
        bus_wr(6'h0C, 4'h2, 32'h8);
        bus_rd(6'h0C, r, er);
        chk("w1c ben off", r, 32'h8);
        bus_wr(6'h0C, 4'h1, 32'h8);
        bus_rd(6'h0C, r, er);
        chk("w1c ben on", r, 32'h0);

        // Back-to-back reads of IN, RISE and an unmapped address.
        gpio_i = 32'h101;
        cyc(2);
        bus_vld = 1'b1;
        bus_wen = 1'b0;
        bus_adr = 6'h08;
        cyc(1);
        chk("b2b IN", bus_rdt, 32'h101);
        chk("b2b IN err", {31'h0, bus_err}, 32'h0);
        bus_adr = 6'h0C;
        cyc(1);
        chk("b2b RISE", bus_rdt, 32'h100);
        chk("b2b RISE err", {31'h0, bus_err}, 32'h0);
        bus_adr = 6'h20;
        cyc(1);
        bus_vld = 1'b0;
        chk("b2b bad", bus_rdt, 32'h0);
        chk("b2b bad err", {31'h0, bus_err}, 32'h1);
`else
        // Debounce with DIV=4: settle low, then a 1-tick glitch and a stable high.
        gpio_i = 32'h0;
        cyc(24);
        bus_wr(6'h0C, 4'hF, 32'hFFFFFFFF);
        bus_wr(6'h10, 4'hF, 32'hFFFFFFFF);
        gpio_i = 32'h20;
        cyc(4);
        gpio_i = 32'h0;
        cyc(20);
        bus_rd(6'h08, r, er);
        chk("glitch IN", r & 32'h20, 32'h0);
        bus_rd(6'h0C, r, er);
        chk("glitch RISE", r & 32'h20, 32'h0);
        gpio_i = 32'h20;
        cyc(16);
        bus_rd(6'h08, r, er);
        chk("stable IN", r & 32'h20, 32'h20);
        bus_rd(6'h0C, r, er);
        chk("stable RISE", r & 32'h20, 32'h20);
`endif

        // Reset asserted during a pending read: response cleared, state reset.
        bus_rd(6'h00, r, er);
        chk("pre-rst rdt", r, 32'h125A5A5A);
        bus_vld = 1'b1;
        bus_wen = 1'b0;
        bus_adr = 6'h08;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        bus_vld = 1'b0;
        chk("midrst rdt", bus_rdt, 32'h0);
        chk("midrst gpio_o", gpio_o, 32'h0);
        chk("midrst gpio_e", gpio_e, 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(2);
        bus_rd(6'h0C, r, er);
        chk("midrst RISE", r, 32'h0);
        bus_rd(6'h10, r, er);
        chk("midrst FALL", r, 32'h0);
        bus_rd(6'h08, r, er);
        chk("midrst IN", r, gpio_i);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
